vector_alu_seq: RTL and testbench

Multi-cycle lane-serial vector/scalar fixed-point ALU, directly downstream of the ALU decoder: consumes its 3-bit `alucontrol` plus register-file operands and produces a packed vector result. Processes one lane per cycle under a start/busy/done handshake, so one shared adder/multiplier serves all lanes. Covers add, sub, mul.fp, vsum.fp (reduction) and vset (broadcast).

---
 rtl/valu_pkg.sv | 26 ++
 rtl/fx_lane_op.sv | 61 ++++++
 rtl/vector_alu_seq.sv | 118 +++++++++++
 tb/tb_vector_alu_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Shared opcodes and FSM state type for the lane-serial vector ALU.
// The ALU decoder imports these same opcode constants.
package valu_pkg;

    localparam logic [2:0] ALU_MUL  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_VSUM = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_VSET = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } valu_state_t;

    function automatic logic is_supported_op(input logic [2:0] op);
        logic ok;
        case (op)
            ALU_MUL, ALU_ADD, ALU_VSUM, ALU_SUB, ALU_VSET: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fx_lane_op.sv
// Combinational single-lane fixed-point add/sub/mul plus reduction of a wide value to WIDTH.
// Define VALU_SATURATE_EN to clamp out-of-range results; otherwise the low WIDTH bits are kept.
module fx_lane_op #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = 18
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [ACCW-1:0]  acc,
    output logic [WIDTH-1:0] y
);
    import valu_pkg::*;

    localparam int XW = 2 * WIDTH;

    logic signed [XW-1:0] a_x;
    logic signed [XW-1:0] b_x;
    logic signed [XW-1:0] acc_x;
    logic signed [XW-1:0] prod;
    logic signed [XW-1:0] wide;

    // Everything is widened to 2*WIDTH so the full product and any sum fit before reduction.
    assign a_x   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_x   = {{WIDTH{b[WIDTH-1]}}, b};
    assign acc_x = {{(XW-ACCW){acc[ACCW-1]}}, acc};
    assign prod  = a_x * b_x;

    always_comb begin
        wide = '0;
        case (op)
            ALU_ADD:  wide = a_x + b_x;
            ALU_SUB:  wide = a_x - b_x;
            ALU_MUL:  wide = prod >>> FRAC;
            ALU_VSUM: wide = acc_x;
            default:  wide = '0;
        endcase
    end

`ifdef VALU_SATURATE_EN
    logic fits;

    assign fits = (wide[XW-1:WIDTH-1] == {(XW-WIDTH+1){wide[WIDTH-1]}});

    always_comb begin
        if (fits)
            y = wide[WIDTH-1:0];
        else if (wide[XW-1])
            y = {1'b1, {(WIDTH-1){1'b0}}};
        else
            y = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    logic unused_high;

    assign y           = wide[WIDTH-1:0];
    assign unused_high = ^wide[XW-1:WIDTH];
`endif

endmodule

// File: rtl/vector_alu_seq.sv
// Lane-serial vector/scalar fixed-point ALU: one lane per cycle through a shared fx_lane_op.
// Optional macro VALU_SATURATE_EN (consumed by fx_lane_op) selects clamping instead of wrap.
module vector_alu_seq #(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             alucontrol,
    input  logic [LANES*WIDTH-1:0] srca,
    input  logic [LANES*WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0]       scalar,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal,
    output logic [LANES*WIDTH-1:0] result
);
    import valu_pkg::*;

    localparam int IDXW = $clog2(LANES);
    localparam int ACCW = WIDTH + IDXW;
    localparam int VW   = LANES * WIDTH;

    valu_state_t state;
    valu_state_t state_next;

    logic [2:0]       op_q;
    logic [VW-1:0]    srca_q;
    logic [VW-1:0]    srcb_q;
    logic [WIDTH-1:0] scalar_q;
    logic [IDXW-1:0]  idx;
    logic [ACCW-1:0]  acc;
    logic [ACCW-1:0]  acc_next;
    logic [WIDTH-1:0] a_lane;
    logic [WIDTH-1:0] b_lane;
    logic [WIDTH-1:0] lane_y;
    logic             accept;
    logic             last_lane;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_lane = (idx == IDXW'(LANES - 1));
    assign a_lane    = srca_q[idx*WIDTH +: WIDTH];
    assign b_lane    = srcb_q[idx*WIDTH +: WIDTH];
    assign acc_next  = acc + {{IDXW{a_lane[WIDTH-1]}}, a_lane};

    // For vsum the lane op sees the accumulator including the current lane, so the
    // final reduction lands on lane 0 in the last RUN cycle.
    fx_lane_op #(
        .WIDTH(WIDTH),
        .FRAC (FRAC),
        .ACCW (ACCW)
    ) u_lane_op (
        .op (op_q),
        .a  (a_lane),
        .b  (b_lane),
        .acc(acc_next),
        .y  (lane_y)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_lane) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ST_RUN);
        done    = (state == ST_DONE);
        illegal = (state == ST_DONE) && !is_supported_op(op_q);
    end

    // Operands are latched at accept so later input changes cannot disturb a running op.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            scalar_q <= '0;
            idx      <= '0;
            acc      <= '0;
            result   <= '0;
        end else if (accept) begin
            op_q     <= alucontrol;
            srca_q   <= srca;
            srcb_q   <= srcb;
            scalar_q <= scalar;
            idx      <= '0;
            acc      <= '0;
            result   <= '0;
        end else if (state == ST_RUN) begin
            idx <= idx + IDXW'(1);
            case (op_q)
                ALU_ADD, ALU_SUB, ALU_MUL: result[idx*WIDTH +: WIDTH] <= lane_y;
                ALU_VSUM: begin
                    acc <= acc_next;
                    if (last_lane)
                        result[WIDTH-1:0] <= lane_y;
                end
                ALU_VSET: result[idx*WIDTH +: WIDTH] <= scalar_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Self-checking bench for vector_alu_seq: integer reference model plus per-cycle compare.
module tb_vector_alu_seq;
    import valu_pkg::*;

    localparam int L = 4;
    localparam int W = 16;
    localparam int F = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    alucontrol = '0;
    logic [L*W-1:0] srca = '0;
    logic [L*W-1:0] srcb = '0;
    logic [W-1:0]  scalar = '0;
    logic          busy;
    logic          done;
    logic          illegal;
    logic [L*W-1:0] result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int op_start = -100;
    logic [L*W-1:0] exp_res = '0;
    logic [L*W-1:0] held_res = '0;
    bit exp_ill = 1'b0;

    vector_alu_seq #(.LANES(L), .WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
        .srca(srca), .srcb(srcb), .scalar(scalar),
        .busy(busy), .done(done), .illegal(illegal), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fit(input longint v);
`ifdef VALU_SATURATE_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[W-1:0];
    endfunction

    function automatic logic [L*W-1:0] model_result(input logic [2:0] op, input logic [L*W-1:0] a,
                                                    input logic [L*W-1:0] b, input logic [W-1:0] s,
                                                    output bit ill);
        logic [L*W-1:0] r = '0;
        longint sa, sb, sum;
        sum = 0;
        ill = 1'b0;
        for (int i = 0; i < L; i++) begin
            sa = longint'($signed(a[i*W +: W]));
            sb = longint'($signed(b[i*W +: W]));
            case (op)
                ALU_ADD:  r[i*W +: W] = fit(sa + sb);
                ALU_SUB:  r[i*W +: W] = fit(sa - sb);
                ALU_MUL:  r[i*W +: W] = fit((sa * sb) >>> F);
                ALU_VSUM: sum = sum + sa;
                ALU_VSET: r[i*W +: W] = s;
                default:  ill = 1'b1;
            endcase
        end
        if (op == ALU_VSUM) r[W-1:0] = fit(sum);
        return r;
    endfunction

    // Per-cycle compare against the model's view of where the current operation is.
    always @(posedge clk) begin
        bit r_seen;
        bit in_run;
        bit is_done;
        r_seen = reset;
        #1;
        if (r_seen) begin
            op_start = -100;
            held_res = '0;
            checkOutput("reset_busy", 64'(busy), 64'd0);
            checkOutput("reset_done", 64'(done), 64'd0);
            checkOutput("reset_illegal", 64'(illegal), 64'd0);
            checkOutput("reset_result", result, 64'd0);
        end else begin
            in_run  = (cyc > op_start) && (cyc <= op_start + L);
            is_done = (cyc == op_start + L + 1);
            checkOutput("busy", 64'(busy), 64'(in_run));
            checkOutput("done", 64'(done), 64'(is_done));
            checkOutput("illegal", 64'(illegal), 64'(is_done && exp_ill));
            if (is_done) begin
                checkOutput("result_done", result, exp_res);
                held_res = exp_res;
            end else if (!in_run) begin
                checkOutput("result_held", result, held_res);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [15:0] s);
        bit ill;
        logic [63:0] r;
        @(negedge clk);
        alucontrol = op;
        srca = a;
        srcb = b;
        scalar = s;
        start = 1'b1;
        if (!((cyc > op_start) && (cyc <= op_start + L))) begin
            r = model_result(op, a, b, s, ill);
            op_start = cyc;
            exp_res = r;
            exp_ill = ill;
        end
        @(negedge clk);
        start = 1'b0;
        alucontrol = 3'($urandom);
        srca = {$urandom, $urandom};
        srcb = {$urandom, $urandom};
        scalar = 16'($urandom);
    endtask

    // Called right after applyStimulus returns: lands #1 into the expected done cycle.
    task automatic checkDoneLiteral(input string name, input logic [63:0] lit, input bit lit_ill);
        repeat (L) @(posedge clk);
        #1;
        checkOutput({name, "_done"}, 64'(done), 64'd1);
        checkOutput({name, "_result"}, result, lit);
        checkOutput({name, "_illegal"}, 64'(illegal), 64'(lit_ill));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] m;
        bit mi;

        m = model_result(ALU_ADD, 64'h0400_0300_0200_0100, 64'h0100_0100_0100_0100, 16'h0, mi);
        checkOutput("pin_model_add", m, 64'h0500_0400_0300_0200);
        m = model_result(ALU_MUL, 64'h0180_0180_0180_0180, 64'h0200_0200_0200_0200, 16'h0, mi);
        checkOutput("pin_model_mul", m, 64'h0300_0300_0300_0300);
        m = model_result(ALU_VSUM, 64'h0400_0300_0200_0100, 64'h0, 16'h0, mi);
        checkOutput("pin_model_vsum", m, 64'h0000_0000_0000_0A00);
        m = model_result(3'b101, 64'h1, 64'h1, 16'h1, mi);
        checkOutput("pin_model_illegal", {m[62:0], mi}, 64'h1);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        applyStimulus(ALU_ADD, 64'h0400_0300_0200_0100, 64'h0100_0100_0100_0100, 16'h0);
        checkDoneLiteral("add", 64'h0500_0400_0300_0200, 1'b0);

        applyStimulus(ALU_MUL, 64'h0180_0180_0180_0180, 64'h0200_0200_0200_0200, 16'h0);
        checkDoneLiteral("mul_pos", 64'h0300_0300_0300_0300, 1'b0);

        applyStimulus(ALU_MUL, 64'hFF80_FF80_FF80_FF80, 64'h0100_0100_0100_0100, 16'h0);
        checkDoneLiteral("mul_neg", 64'hFF80_FF80_FF80_FF80, 1'b0);

        applyStimulus(ALU_VSUM, 64'h0400_0300_0200_0100, 64'hDEAD_BEEF_1234_5678, 16'h0);
        checkDoneLiteral("vsum", 64'h0000_0000_0000_0A00, 1'b0);

`ifdef VALU_SATURATE_EN
        applyStimulus(ALU_ADD, 64'h7F00_7F00_7F00_7F00, 64'h0200_0200_0200_0200, 16'h0);
        checkDoneLiteral("add_ovf", 64'h7FFF_7FFF_7FFF_7FFF, 1'b0);
        applyStimulus(ALU_SUB, 64'h0000_7FFF_8000_0100, 64'h0001_FFFF_0100_0300, 16'h0);
        checkDoneLiteral("sub_ovf", 64'hFFFF_7FFF_8000_FE00, 1'b0);
        applyStimulus(ALU_VSUM, 64'h7000_7000_7000_7000, 64'h0, 16'h0);
        checkDoneLiteral("vsum_ovf", 64'h0000_0000_0000_7FFF, 1'b0);
`else
        applyStimulus(ALU_ADD, 64'h7F00_7F00_7F00_7F00, 64'h0200_0200_0200_0200, 16'h0);
        checkDoneLiteral("add_ovf", 64'h8100_8100_8100_8100, 1'b0);
        applyStimulus(ALU_SUB, 64'h0000_7FFF_8000_0100, 64'h0001_FFFF_0100_0300, 16'h0);
        checkDoneLiteral("sub_ovf", 64'hFFFF_8000_7F00_FE00, 1'b0);
        applyStimulus(ALU_VSUM, 64'h7000_7000_7000_7000, 64'h0, 16'h0);
        checkDoneLiteral("vsum_ovf", 64'h0000_0000_0000_C000, 1'b0);
`endif

        // vset, then relaunch with an unsupported code in the DONE cycle.
        applyStimulus(ALU_VSET, 64'h0, 64'h0, 16'h1234);
        checkDoneLiteral("vset", 64'h1234_1234_1234_1234, 1'b0);
        applyStimulus(3'b101, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 16'h9999);
        checkDoneLiteral("illegal_op", 64'h0, 1'b1);

        // A start during RUN must be ignored; the add completes untouched.
        applyStimulus(ALU_ADD, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 16'h0);
        applyStimulus(ALU_VSET, 64'h0, 64'h0, 16'hABCD);
        repeat (L - 2) @(posedge clk);
        #1;
        checkOutput("ignored_start_result", result, 64'h0011_0022_0033_0044);
        checkOutput("ignored_start_done", 64'(done), 64'd1);

        // Reset in cycle 2 of an add aborts it; compare process checks the zeroed outputs.
        applyStimulus(ALU_ADD, 64'h0400_0300_0200_0100, 64'h0100_0100_0100_0100, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_result", result, 64'd0);
        applyStimulus(ALU_SUB, 64'h0400_0300_0200_0100, 64'h0100_0100_0100_0100, 16'h0);
        checkDoneLiteral("after_reset", 64'h0300_0200_0100_0000, 1'b0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
